// File: rtl/jt7759_romcache_if.sv
// Bus bundle for jt7759_romcache: ADPCM ROM-port request side and 32-bit memory side.
// slave modport is the cache; master modport is whatever drives requests and memory.
interface jt7759_romcache_if;
  logic        flush;
  logic        cs_in;
  logic [16:0] addr_in;
  logic [7:0]  data_out;
  logic        ok_out;
  logic        mem_cs;
  logic [14:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ok;

  modport slave (
    input  flush, cs_in, addr_in, mem_data, mem_ok,
    output data_out, ok_out, mem_cs, mem_addr
  );

  modport master (
    output flush, cs_in, addr_in, mem_data, mem_ok,
    input  data_out, ok_out, mem_cs, mem_addr
  );
endinterface

// File: rtl/jt7759_romcache.sv
// Single-line 32-bit word cache in front of the JT7759 ADPCM ROM port.
// Optional macro JT7759_CACHE_PREFETCH_EN adds a prefetch buffer that fetches the next word
// (tag+1, wrapping) after every demand fill or promotion.
module jt7759_romcache (
  input  logic                    clk,
  input  logic                    rst,
  jt7759_romcache_if.slave        bus
);

`ifdef JT7759_CACHE_PREFETCH_EN
  typedef enum logic [1:0] {StIdle, StFetch, StPref} state_e;
`else
  typedef enum logic [1:0] {StIdle, StFetch} state_e;
`endif

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [14:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;
  logic        mem_cs_q, mem_cs_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  // Set once mem_cs has been high for a full cycle of the current request; masks stale mem_ok.
  logic        armed_q, armed_d;

  logic [14:0] req_word;
  logic        hit;
  logic        accept;

  assign req_word = bus.addr_in[16:2];
  assign accept   = bus.mem_ok & mem_cs_q & armed_q;
  assign armed_d  = mem_cs_q & ~accept;

  // Main line is only unavailable while it is being refilled; a prefetch only writes the
  // prefetch buffer, so the main line keeps serving hits during it.
  assign hit = bus.cs_in & valid_q & (tag_q == req_word) & (state_q != StFetch) & ~rst;

`ifdef JT7759_CACHE_PREFETCH_EN
  logic        pref_valid_q, pref_valid_d;
  logic [14:0] pref_tag_q, pref_tag_d;
  logic [31:0] pref_data_q, pref_data_d;
  logic        pref_hit;

  assign pref_hit = pref_valid_q & (pref_tag_q == req_word);
`endif

  // Next-state logic: miss handling, fill acceptance and flush.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    mem_cs_d   = mem_cs_q;
    mem_addr_d = mem_addr_q;
`ifdef JT7759_CACHE_PREFETCH_EN
    pref_valid_d = pref_valid_q;
    pref_tag_d   = pref_tag_q;
    pref_data_d  = pref_data_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.cs_in && !hit) begin
          state_d    = StFetch;
          mem_cs_d   = 1'b1;
          mem_addr_d = req_word;
`ifdef JT7759_CACHE_PREFETCH_EN
          if (pref_hit) begin
            valid_d      = 1'b1;
            tag_d        = pref_tag_q;
            data_d       = pref_data_q;
            pref_valid_d = 1'b0;
            state_d      = StPref;
            mem_addr_d   = pref_tag_q + 15'd1;
          end
`endif
        end
      end
      StFetch: begin
        if (accept) begin
          data_d  = bus.mem_data;
          tag_d   = mem_addr_q;
          valid_d = 1'b1;
`ifdef JT7759_CACHE_PREFETCH_EN
          // Keep mem_cs up and roll straight into the next-word prefetch.
          state_d    = StPref;
          mem_addr_d = mem_addr_q + 15'd1;
`else
          state_d  = StIdle;
          mem_cs_d = 1'b0;
`endif
        end
      end
`ifdef JT7759_CACHE_PREFETCH_EN
      StPref: begin
        if (accept) begin
          pref_data_d  = bus.mem_data;
          pref_tag_d   = mem_addr_q;
          pref_valid_d = 1'b1;
          mem_cs_d     = 1'b0;
          state_d      = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    // Flush wins over a simultaneous fill but never aborts an outstanding fetch.
    if (bus.flush) begin
      valid_d = 1'b0;
`ifdef JT7759_CACHE_PREFETCH_EN
      pref_valid_d = 1'b0;
`endif
    end
  end

  // State and line registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      data_q     <= '0;
      mem_cs_q   <= 1'b0;
      mem_addr_q <= '0;
      armed_q    <= 1'b0;
`ifdef JT7759_CACHE_PREFETCH_EN
      pref_valid_q <= 1'b0;
      pref_tag_q   <= '0;
      pref_data_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      mem_cs_q   <= mem_cs_d;
      mem_addr_q <= mem_addr_d;
      armed_q    <= armed_d;
`ifdef JT7759_CACHE_PREFETCH_EN
      pref_valid_q <= pref_valid_d;
      pref_tag_q   <= pref_tag_d;
      pref_data_q  <= pref_data_d;
`endif
    end
  end

  // Little-endian byte select from the main line.
  always_comb begin
    bus.data_out = data_q[7:0];
    unique case (bus.addr_in[1:0])
      2'd0: bus.data_out = data_q[7:0];
      2'd1: bus.data_out = data_q[15:8];
      2'd2: bus.data_out = data_q[23:16];
      2'd3: bus.data_out = data_q[31:24];
      default: bus.data_out = data_q[7:0];
    endcase
  end

  assign bus.ok_out   = hit;
  assign bus.mem_cs   = mem_cs_q;
  assign bus.mem_addr = mem_addr_q;

endmodule

// File: doc/jt7759_romcache.md
JT7759_ROMCACHE -- requirements
Module: jt7759_romcache

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clk  input  1  system clock, same as sound CPU clock.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 flush  input  1  invalidates all cached lines; use on ROM download.
REQ-005 cs_in  input  1  byte request from ADPCM chip ROM port.
REQ-006 addr_in  input  17  byte address.
REQ-007 data_out  output  8  byte at addr_in; valid when ok_out=1.
REQ-008 ok_out  output  1  data_out valid for the current addr_in.
REQ-009 mem_cs  output  1  external 32-bit memory request.
REQ-010 mem_addr  output  15  word address, equal to the byte address bits [16:2].
REQ-011 mem_data  input  32  memory word, little-endian: byte 0 in bits [7:0].
REQ-012 mem_ok  input  1  mem_data valid.

Function
REQ-013 The main line SHALL hold: valid bit, 15-bit tag, 32-bit data.
REQ-014 Hit SHALL mean cs_in & valid & tag==addr_in[16:2] & state==IDLE.
REQ-015 On a hit, ok_out=1 and data_out=data byte addr_in[1:0], combinationally, with no cycle of latency.
REQ-016 ok_out SHALL be 0 whenever cs_in=0 or there is no hit.
REQ-017 When ok_out=0, data_out SHALL still show the muxed byte; its value is don't-care.
REQ-018 FSM states SHALL be IDLE, FETCH and, under the configuration macro only, PREF.
REQ-019 In IDLE, a request that misses (cs_in=1, no hit) SHALL latch addr_in[16:2] into mem_addr, set mem_cs=1, and go to FETCH on the next clk.
REQ-020 In FETCH, mem_cs SHALL stay 1 and mem_addr SHALL stay stable.
REQ-021 mem_ok SHALL be accepted only when mem_cs was already 1 in the previous cycle; this masks stale ok from the controller.
REQ-022 On acceptance: data←mem_data, tag←mem_addr, valid←1, mem_cs←0, next state IDLE.
REQ-023 A change of addr_in or a drop of cs_in during FETCH SHALL NOT abort the fetch; the fill completes and hit is then re-evaluated in IDLE.
REQ-024 flush=1 SHALL clear all valid bits on that clk.
REQ-025 If flush coincides with a fill acceptance, flush wins: valid=0.
REQ-026 flush SHALL NOT abort an outstanding fetch.
REQ-027 Latency: a miss with mem_ok arriving k cycles after mem_cs rises (k≥1) SHALL give ok_out=1 at cycle k+2 after the request.
REQ-028 Back-to-back requests to the same word SHALL all hit after the first fill.

Reset
REQ-029 On rst: state=IDLE, all valid bits=0, mem_cs=0, mem_addr=0, tags=0, data=0.
REQ-030 ok_out SHALL be 0 during rst and after reset until the first fill.
REQ-031 Reset mid-FETCH SHALL drop mem_cs on the next clk and discard the fill.

Configuration
REQ-032 The macro JT7759_CACHE_PREFETCH_EN, when defined, SHALL add a second line (PREF buffer: valid, tag, data).
REQ-033 With the macro defined, after every demand fill the FSM SHALL enter PREF and fetch word tag+1.
REQ-034 The prefetch word address SHALL wrap from 0x7FFF to 0x0000.
REQ-035 The prefetch SHALL use the same mem_ok acceptance rule as a demand fetch and then return to IDLE.
REQ-036 In IDLE, a request that misses main but matches a valid PREF SHALL promote PREF into main in one clk.
REQ-037 After a promotion, PREF SHALL be invalidated and a prefetch of the new tag+1 SHALL start.
REQ-038 ok_out SHALL assert after the promotion, one clk after the request.
REQ-039 A demand miss arriving during PREF SHALL wait for the prefetch to complete, then be re-evaluated.
REQ-040 Without the macro: single line, no PREF state, and mem_cs is only ever raised by demand misses.

Verification
REQ-041 After reset: cs_in=1, addr_in=0x00005 -> mem_cs=1, mem_addr=0x0001; mem_ok=1 with mem_data=0xDDCCBBAA two cycles later -> ok_out=1, data_out=0xBB; then addr_in=0x00007 -> data_out=0xDD with ok_out=1 in the same cycle and mem_cs=0.
REQ-042 Stale-ok check: mem_ok held high continuously; miss at 0x1FFFC -> the first mem_cs cycle is ignored and the fill is accepted on the second, giving mem_addr=0x7FFF.
REQ-043 addr_in 0x00010 -> 0x00020 during FETCH -> fill completes for tag 0x0004 first, then a new FETCH with mem_addr=0x0008.
REQ-044 Cached line present; flush=1 in the same cycle as a fill acceptance -> next request to that word misses and mem_cs=1.
REQ-045 Macro defined: miss at 0x1FFFE, fill done -> PREF fetch with mem_addr=0x0000; then request 0x00001 -> promotion, ok_out=1 one clk later, no demand fetch, and a new prefetch with mem_addr=0x0001.
REQ-046 rst=1 asserted during FETCH -> mem_cs=0 and ok_out=0 the next cycle; a later request to the same address issues a fresh fetch.
